// File: rtl/nibble_serial_addsub_if.sv
// Handshake and operand/result bundle for the nibble-serial adder/subtractor.
// The master drives the request; the slave (the datapath) returns the result.
interface nibble_serial_addsub_if;
    logic       start;
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       done;

    modport master (
        output start, m, a, b,
        input  ready, s, c, v, done
    );

    modport slave (
        input  start, m, a, b,
        output ready, s, c, v, done
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// 8-bit add/subtract that runs one 4-bit nibble per cycle through a single shared adder.
// The result is published all at once when the high nibble completes.
module nibble_serial_addsub (
    input  logic                          clk,
    input  logic                          rst,
    nibble_serial_addsub_if.slave         bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLow  = 2'd1;
    localparam logic [1:0] StHigh = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_m;
    logic [3:0] r_lo;
    logic       r_nc;
    logic [7:0] r_s;
    logic       r_c;
    logic       r_v;
    logic       r_done;

    logic [3:0] w_na;
    logic [3:0] w_nb;
    logic       w_cin;
    logic [4:0] w_nsum;
    logic       w_c7;

    // One nibble adder: low half in StLow, high half otherwise; subtract inverts b with cin = m.
    always_comb begin
        w_na  = r_a[7:4];
        w_nb  = r_b[7:4] ^ {4{r_m}};
        w_cin = r_nc;
        if (r_state == StLow) begin
            w_na  = r_a[3:0];
            w_nb  = r_b[3:0] ^ {4{r_m}};
            w_cin = r_m;
        end
    end

    assign w_nsum = {1'b0, w_na} + {1'b0, w_nb} + {4'b0000, w_cin};
    // Carry into the nibble's top bit, i.e. into bit 7 during the high pass.
    assign w_c7   = w_nsum[3] ^ w_na[3] ^ w_nb[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_m     <= 1'b0;
            r_lo    <= 4'h0;
            r_nc    <= 1'b0;
            r_s     <= 8'h00;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_m     <= bus.m;
                        r_state <= StLow;
                    end
                end
                StLow: begin
                    r_lo    <= w_nsum[3:0];
                    r_nc    <= w_nsum[4];
                    r_state <= StHigh;
                end
                StHigh: begin
                    r_s     <= {w_nsum[3:0], r_lo};
                    r_c     <= w_nsum[4];
                    r_v     <= w_c7 ^ w_nsum[4];
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.ready = (r_state == StIdle);
    assign bus.s     = r_s;
    assign bus.c     = r_c;
    assign bus.v     = r_v;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench: stimulus pushes expected {s,c,v}; a negedge monitor pops on each done pulse.
module tb_nibble_serial_addsub;

    logic clk;
    logic rst;

    nibble_serial_addsub_if bus ();

    nibble_serial_addsub dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [9:0]  exp_q[$];

    // Directed table: {m, a, b, s, c, v}
    typedef struct packed {
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    localparam int NumDir = 12;
    vec_t dir_tab [NumDir] = '{
        '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0},
        '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0},
        '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1},
        '{1'b1, 8'h50, 8'h70, 8'hE0, 1'b0, 1'b0},
        '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1},
        '{1'b0, 8'h3A, 8'h25, 8'h5F, 1'b0, 1'b0},
        '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0},
        '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1},
        '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1},
        '{1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0},
        '{1'b1, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0},
        '{1'b0, 8'h08, 8'h08, 8'h10, 1'b0, 1'b0}
    };

    // Whole-word reference: 9-bit sum; overflow when like-signed operands give an opposite sign.
    function automatic logic [9:0] ref_op(input logic m, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] bb;
        logic [8:0] sum;
        logic       ov;
        bb  = m ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {8'h00, m};
        ov  = (a[7] == bb[7]) && (sum[7] != a[7]);
        return {sum[7:0], sum[8], ov};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Called aligned to posedge+1; returns aligned to posedge+1 with ready high (or a failure noted).
    task automatic wait_ready();
        int w;
        w = 0;
        while (bus.ready !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (bus.ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles", bus.ready, w);
        end
    endtask

    // Present one request for one edge, then scramble operands to prove they were captured.
    task automatic issue(input logic m_i, input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic [9:0] exp_i, input bit push);
        wait_ready();
        bus.start = 1'b1;
        bus.m     = m_i;
        bus.a     = a_i;
        bus.b     = b_i;
        if (push) exp_q.push_back(exp_i);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.m     = 1'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // Monitor: compare on done, flag stray or doubled pulses, and enforce result hold.
    logic [9:0] prev_scv;
    logic       prev_done = 1'b0;
    logic       prev_rst  = 1'b1;

    always @(negedge clk) begin
        logic [9:0] exp;
        logic [9:0] act;
        act = {bus.s, bus.c, bus.v};
        if (bus.done === 1'b1) begin
            n_vec++;
            if (prev_done) begin
                n_err++;
                $display("FAIL done_width: done high two cycles, expected one");
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got done with s=%0h c=%b v=%b, expected none",
                         bus.s, bus.c, bus.v);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL result: got s=%0h c=%b v=%b, expected s=%0h c=%b v=%b",
                             act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
                end
            end
        end else if (!prev_rst && act !== prev_scv) begin
            n_vec++;
            n_err++;
            $display("FAIL hold: s/c/v changed to %0h without done, expected %0h", act, prev_scv);
        end
        prev_scv  = act;
        prev_done = (bus.done === 1'b1);
        prev_rst  = rst;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bv;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.m     = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s", 32'(bus.s), 32'h00);
        check("rst_c", 32'(bus.c), 32'h0);
        check("rst_v", 32'(bus.v), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h1);

        // First start on the first edge after reset release, with latency checks.
        rst = 1'b0;
        issue(dir_tab[0].m, dir_tab[0].a, dir_tab[0].b,
              {dir_tab[0].s, dir_tab[0].c, dir_tab[0].v}, 1'b1);
        check("e0_ready", 32'(bus.ready), 32'h0);
        check("e0_done", 32'(bus.done), 32'h0);
        @(posedge clk);
        #1;
        check("e1_ready", 32'(bus.ready), 32'h0);
        check("e1_done", 32'(bus.done), 32'h0);
        check("e1_s_hold", 32'(bus.s), 32'h00);
        @(posedge clk);
        #1;
        check("e2_done", 32'(bus.done), 32'h1);
        check("e2_ready", 32'(bus.ready), 32'h1);

        for (int i = 1; i < NumDir; i++) begin
            issue(dir_tab[i].m, dir_tab[i].a, dir_tab[i].b,
                  {dir_tab[i].s, dir_tab[i].c, dir_tab[i].v}, 1'b1);
        end
        drain();

        // start held high with a changing every cycle: accepted at k = 0, 3, 6 only.
        wait_ready();
        for (int k = 0; k < 9; k++) begin
            bus.start = 1'b1;
            bus.m     = 1'b0;
            bus.a     = 8'h10 + 8'(k);
            bus.b     = 8'h01;
            check("b2b_ready", 32'(bus.ready), (k % 3 == 0) ? 32'h1 : 32'h0);
            if (k % 3 == 0) exp_q.push_back({8'h11 + 8'(k), 1'b0, 1'b0});
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        drain();

        // Reset one edge after acceptance abandons the operation.
        issue(1'b0, 8'h3A, 8'h25, 10'h000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", 32'(bus.ready), 32'h1);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_s", 32'(bus.s), 32'h00);
        repeat (4) @(posedge clk);
        #1;
        issue(1'b0, 8'h3A, 8'h25, {8'h5F, 1'b0, 1'b0}, 1'b1);
        drain();

        // Strided sweep against the whole-word reference.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int mm = 0; mm < 2; mm++) begin
                    bv = 8'(j * 16 + (15 - j));
                    issue(1'(mm), 8'(i * 17), bv, ref_op(1'(mm), 8'(i * 17), bv), 1'b1);
                end
            end
        end
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
